// File: rtl/dm_sched_pkg.sv
// Shared constants, types and helpers for the DataMover command scheduler.
// Holds command/status field positions and the outstanding-entry layout.
package dm_sched_pkg;

  localparam int CMD_W         = 72;
  localparam int CMD_BTT_LSB   = 0;
  localparam int CMD_BTT_W     = 23;
  localparam int CMD_TYPE_BIT  = 23;
  localparam int CMD_EOF_BIT   = 30;
  localparam int CMD_SADDR_LSB = 32;
  localparam int CMD_TAG_LSB   = 64;

  localparam int STS_TAG_LSB    = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

  localparam logic [7:0] STS_LOCAL_ZERO_BTT = 8'h10;

  localparam int ID_W_MAX = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } arb_state_e;

  // Outstanding entry: lcl marks a zero-length request answered locally.
  typedef struct packed {
    logic                lcl;
    logic [ID_W_MAX-1:0] id;
  } ent_t;

  function automatic logic [CMD_W-1:0] mk_cmd(
    input logic [31:0] addr,
    input logic [22:0] btt,
    input logic [3:0]  tag
  );
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_BTT_LSB +: CMD_BTT_W] = btt;
    c[CMD_TYPE_BIT]             = 1'b1;
    c[CMD_EOF_BIT]              = 1'b1;
    c[CMD_SADDR_LSB +: 32]      = addr;
    c[CMD_TAG_LSB +: 4]         = tag;
    return c;
  endfunction

endpackage

// File: rtl/dm_sched_fifo.sv
// In-order tracker of issued commands: synchronous FIFO with count.
// DEPTH must be a power of two so pointers wrap naturally.
module dm_sched_fifo #(
  parameter  int W     = 5,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (!do_push && do_pop)
      count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/datamover_cmd_sched.sv
// Round-robin sharing of one DataMover cmd/status pair among requesters.
// Optional: define DM_SCHED_TAG_CHECK_EN to flag status tag mismatches.
module datamover_cmd_sched
  import dm_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int MAX_OUT = 8,
  parameter  int IDW     = 4,
  localparam int CW      = $clog2(MAX_OUT) + 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [23*NUM_REQ-1:0] req_btt,
  output logic [NUM_REQ-1:0]    req_sts_valid,
  input  logic [NUM_REQ-1:0]    req_sts_ready,
  output logic [7:0]            req_sts_data,
  output logic                  m_axis_cmd_tvalid,
  input  logic                  m_axis_cmd_tready,
  output logic [71:0]           m_axis_cmd_tdata,
  input  logic                  s_axis_sts_tvalid,
  output logic                  s_axis_sts_tready,
  input  logic [7:0]            s_axis_sts_tdata,
  output logic [CW-1:0]         outstanding,
  output logic [2:0]            err_sticky,
  input  logic                  err_clr
);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      gnt_id, hi_id, lo_id;
  logic                hi_f, lo_f, gnt_found, grant;
  logic [ID_W_MAX-1:0] gnt_tag;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [31:0]         sel_addr;
  logic [22:0]         sel_btt;
  logic                btt_nz;
  ent_t                push_ent, head;
  logic [$bits(ent_t)-1:0] fifo_dout;
  logic                fifo_full, fifo_empty, pop;
  logic [2:0]          err_q, err_d;
  logic                dm_hs, spurious, tag_err;

  dm_sched_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push_i  (grant),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  assign head       = ent_t'(fifo_dout);
  assign err_sticky = err_q;

  // Round-robin pick: lowest valid at/above rr_q, else lowest below it.
  always_comb begin
    hi_f  = 1'b0;
    lo_f  = 1'b0;
    hi_id = '0;
    lo_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) >= rr_q) begin
          hi_f  = 1'b1;
          hi_id = IDW'(i);
        end else begin
          lo_f  = 1'b1;
          lo_id = IDW'(i);
        end
      end
    end
    gnt_found = hi_f | lo_f;
    gnt_id    = hi_f ? hi_id : lo_id;
  end

  // Winner's address/length, pointer advance and command build.
  always_comb begin
    sel_addr = '0;
    sel_btt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_addr = req_addr[32*i +: 32];
        sel_btt  = req_btt[23*i +: 23];
      end
    end
    btt_nz       = |sel_btt;
    grant        = aresetn & (state_q == S_IDLE) & gnt_found & ~fifo_full;
    gnt_tag      = '0;
    gnt_tag[IDW-1:0] = gnt_id;
    push_ent.lcl = ~btt_nz;
    push_ent.id  = gnt_tag;
    rr_d         = rr_q;
    if (grant)
      rr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    cmd_d = cmd_q;
    if (grant && btt_nz)
      cmd_d = mk_cmd(sel_addr, sel_btt, gnt_tag);
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!aresetn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Arbiter next state: hold the command until the DataMover takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant && btt_nz) state_d = S_ISSUE;
      S_ISSUE: if (m_axis_cmd_tready) state_d = S_IDLE;
    endcase
  end

  // Arbiter outputs.
  always_comb begin
    m_axis_cmd_tvalid = (state_q == S_ISSUE);
    m_axis_cmd_tdata  = cmd_q;
    req_ready         = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant && gnt_id == IDW'(i))
        req_ready[i] = 1'b1;
  end

  // Datapath registers: RR pointer, command word, sticky errors.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rr_q  <= '0;
      cmd_q <= '0;
      err_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cmd_q <= cmd_d;
      err_q <= err_d;
    end
  end

  // Status routing from the FIFO head; empty FIFO swallows status.
  always_comb begin
    req_sts_valid     = '0;
    req_sts_data      = '0;
    s_axis_sts_tready = 1'b0;
    pop               = 1'b0;
    dm_hs             = 1'b0;
    spurious          = 1'b0;
    if (aresetn) begin
      if (fifo_empty) begin
        s_axis_sts_tready = 1'b1;
        dm_hs             = s_axis_sts_tvalid;
        spurious          = s_axis_sts_tvalid;
      end else if (!head.lcl) begin
        req_sts_data = s_axis_sts_tdata;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (head.id == 4'(i)) begin
            req_sts_valid[i]  = s_axis_sts_tvalid;
            s_axis_sts_tready = req_sts_ready[i];
          end
        end
        dm_hs = s_axis_sts_tvalid & s_axis_sts_tready;
        pop   = dm_hs;
      end else begin
        req_sts_data = STS_LOCAL_ZERO_BTT | {4'b0, head.id};
        for (int i = 0; i < NUM_REQ; i++) begin
          if (head.id == 4'(i)) begin
            req_sts_valid[i] = 1'b1;
            pop              = req_sts_ready[i];
          end
        end
      end
    end
  end

`ifdef DM_SCHED_TAG_CHECK_EN
  assign tag_err = dm_hs & ~fifo_empty &
                   (s_axis_sts_tdata[STS_TAG_LSB +: 4] != head.id);
`else
  assign tag_err = 1'b0;
`endif

  // Sticky errors: a new error in the clear cycle still sets.
  always_comb begin
    err_d    = err_clr ? 3'b000 : err_q;
    err_d[0] = err_d[0] | spurious;
    err_d[1] = err_d[1] | (dm_hs & ~s_axis_sts_tdata[STS_OKAY_BIT]);
    err_d[2] = err_d[2] | tag_err;
  end

endmodule

// File: tb/tb_datamover_cmd_sched.sv
// Directed self-checking bench for datamover_cmd_sched.
// Immediate assertions count and report each mismatch.
module tb_datamover_cmd_sched;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_addr;
  logic [23*N-1:0] req_btt;
  logic [N-1:0]    req_sts_valid;
  logic [N-1:0]    req_sts_ready;
  logic [7:0]      req_sts_data;
  logic            m_axis_cmd_tvalid;
  logic            m_axis_cmd_tready;
  logic [71:0]     m_axis_cmd_tdata;
  logic            s_axis_sts_tvalid;
  logic            s_axis_sts_tready;
  logic [7:0]      s_axis_sts_tdata;
  logic [CW-1:0]   outstanding;
  logic [2:0]      err_sticky;
  logic            err_clr;

  int tests = 0;
  int fails = 0;
  int gcount;
  logic [3:0] exp_rdy;
  logic [2:0] exp_tag_err;

  always #5 clk = ~clk;

  datamover_cmd_sched #(.NUM_REQ(N), .MAX_OUT(8), .IDW(4)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_btt           (req_btt),
    .req_sts_valid     (req_sts_valid),
    .req_sts_ready     (req_sts_ready),
    .req_sts_data      (req_sts_data),
    .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
    .m_axis_cmd_tready (m_axis_cmd_tready),
    .m_axis_cmd_tdata  (m_axis_cmd_tdata),
    .s_axis_sts_tvalid (s_axis_sts_tvalid),
    .s_axis_sts_tready (s_axis_sts_tready),
    .s_axis_sts_tdata  (s_axis_sts_tdata),
    .outstanding       (outstanding),
    .err_sticky        (err_sticky),
    .err_clr           (err_clr)
  );

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn           = 1'b0;
    req_valid         = '0;
    req_addr          = '0;
    req_btt           = '0;
    req_sts_ready     = '0;
    m_axis_cmd_tready = 1'b0;
    s_axis_sts_tvalid = 1'b0;
    s_axis_sts_tdata  = '0;
    err_clr           = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", m_axis_cmd_tvalid, 0);
    chk("rst_outst", outstanding, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_stsrdy", s_axis_sts_tready, 0);
    aresetn = 1'b1;
    tick();

    // Single request from requester 1.
    req_addr[32*1 +: 32] = 32'h1000_0000;
    req_btt[23*1 +: 23]  = 23'd64;
    req_valid            = 4'b0010;
    #1;
    chk("single_rdy", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("single_tvalid", m_axis_cmd_tvalid, 1);
    chk("single_tdata", m_axis_cmd_tdata, 72'h0_1_10000000_4080_0040);
    chk("single_outst", outstanding, 1);
    chk("single_rdy_off", req_ready, 0);
    m_axis_cmd_tready = 1'b1;
    tick();
    m_axis_cmd_tready = 1'b0;
    chk("single_tv_drop", m_axis_cmd_tvalid, 0);
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h81;
    req_sts_ready     = 4'b0010;
    #1;
    chk("single_stsv", req_sts_valid, 4'b0010);
    chk("single_stsd", req_sts_data, 8'h81);
    chk("single_ststr", s_axis_sts_tready, 1);
    tick();
    s_axis_sts_tvalid = 1'b0;
    req_sts_ready     = '0;
    #1;
    chk("single_outst0", outstanding, 0);
    chk("single_err", err_sticky, 0);

    // Fairness with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = 32'h2000_0000 + 32'(i * 32'h100);
      req_btt[23*i +: 23]  = 23'd16;
    end
    req_valid         = 4'b1111;
    m_axis_cmd_tready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_rdy = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0;
      chk($sformatf("fair_rdy%0d", c), req_ready, exp_rdy);
      if (c % 2 == 1)
        chk($sformatf("fair_tag%0d", c), m_axis_cmd_tdata[67:64],
            72'((c / 2) % 4));
      tick();
    end
    req_valid = '0;
    #1;
    chk("fair_outst", outstanding, 6);

    // Backpressure: no status returned, FIFO fills.
    do_reset();
    req_valid         = 4'b1111;
    m_axis_cmd_tready = 1'b1;
    gcount            = 0;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (req_ready != '0) gcount++;
      tick();
    end
    chk("full_grants", 72'(gcount), 8);
    chk("full_outst", outstanding, 8);
    chk("full_rdy", req_ready, 0);
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h80;
    req_sts_ready     = 4'b0001;
    #1;
    chk("full_stsv", req_sts_valid, 4'b0001);
    tick();
    s_axis_sts_tvalid = 1'b0;
    req_sts_ready     = '0;
    #1;
    chk("full_regrant", req_ready, 4'b0001);
    chk("full_outst7", outstanding, 7);
    tick();
    req_valid = '0;
    #1;
    chk("full_outst8", outstanding, 8);

    // Zero-length request behind a real one.
    do_reset();
    req_btt[23*0 +: 23] = 23'd16;
    req_btt[23*2 +: 23] = 23'd0;
    req_valid           = 4'b0101;
    m_axis_cmd_tready   = 1'b1;
    #1;
    chk("zb_rdy0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("zb_tv0", m_axis_cmd_tvalid, 1);
    tick();
    chk("zb_rdy2", req_ready, 4'b0100);
    chk("zb_tv_idle", m_axis_cmd_tvalid, 0);
    tick();
    req_valid = '0;
    #1;
    chk("zb_no_cmd", m_axis_cmd_tvalid, 0);
    chk("zb_outst", outstanding, 2);
    chk("zb_wait", req_sts_valid, 4'b0000);
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h80;
    req_sts_ready     = 4'b0101;
    #1;
    chk("zb_sts0", req_sts_valid, 4'b0001);
    chk("zb_sts0d", req_sts_data, 8'h80);
    tick();
    s_axis_sts_tvalid = 1'b0;
    #1;
    chk("zb_sts2", req_sts_valid, 4'b0100);
    chk("zb_sts2d", req_sts_data, 8'h12);
    chk("zb_noconsume", s_axis_sts_tready, 0);
    tick();
    req_sts_ready = '0;
    #1;
    chk("zb_outst0", outstanding, 0);
    chk("zb_err", err_sticky, 0);

    // Errors: spurious non-OKAY status, clear, set-wins.
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h40;
    #1;
    chk("err_drop_rdy", s_axis_sts_tready, 1);
    tick();
    s_axis_sts_tvalid = 1'b0;
    #1;
    chk("err_set", err_sticky, 3'b011);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("err_clr", err_sticky, 3'b000);
    err_clr           = 1'b1;
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h80;
    tick();
    err_clr           = 1'b0;
    s_axis_sts_tvalid = 1'b0;
    #1;
    chk("err_setwins", err_sticky, 3'b001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("err_clr2", err_sticky, 3'b000);

    // Tag check: status tag 3 returned against head id 1.
    req_btt[23*1 +: 23] = 23'd8;
    req_valid           = 4'b0010;
    m_axis_cmd_tready   = 1'b1;
    #1;
    chk("tag_rdy", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    s_axis_sts_tvalid = 1'b1;
    s_axis_sts_tdata  = 8'h83;
    req_sts_ready     = 4'b0010;
    #1;
    chk("tag_route", req_sts_valid, 4'b0010);
    chk("tag_data", req_sts_data, 8'h83);
    tick();
    s_axis_sts_tvalid = 1'b0;
    req_sts_ready     = '0;
`ifdef DM_SCHED_TAG_CHECK_EN
    exp_tag_err = 3'b100;
`else
    exp_tag_err = 3'b000;
`endif
    #1;
    chk("tag_err", err_sticky, exp_tag_err);

    // Reset while a command is being offered.
    do_reset();
    req_valid         = 4'b0010;
    m_axis_cmd_tready = 1'b0;
    tick();
    req_valid = '0;
    #1;
    chk("rmid_tv", m_axis_cmd_tvalid, 1);
    chk("rmid_outst", outstanding, 1);
    aresetn = 1'b0;
    tick();
    chk("rmid_tv0", m_axis_cmd_tvalid, 0);
    chk("rmid_outst0", outstanding, 0);
    chk("rmid_rdy0", req_ready, 0);
    aresetn   = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rmid_rr0", req_ready, 4'b0001);
    tick();
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
